// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the fetch and memory stages.
//   clk, reset                 clock, asynchronous active-high reset
//   i_req/i_addr               fetch request; i_rdata/i_valid fetch response
//   d_req/d_we/d_addr/d_wdata/d_be   load/store request; d_rdata/d_valid response
//   StallF, StallM             stall while a request is pending and not yet answered
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be, mem_ready   shared memory request
//   mem_rvalid, mem_rdata      shared memory response
// Define ARB_RR_EN to break fetch/data ties round-robin; otherwise data always wins.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_valid,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_valid,
    output logic                StallF,
    output logic                StallM,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);
    typedef enum logic [2:0] {IDLE, REQ_I, REQ_D, WAIT_I, WAIT_D} state_t;
    state_t state;
    logic   pick_d;
`ifdef ARB_RR_EN
    // last_i = 1 when fetch held the most recent grant, so data wins the next tie
    logic last_i;
    assign pick_d = d_req && (!i_req || last_i);
`else
    assign pick_d = d_req;
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            mem_req <= 1'b0;
`ifdef ARB_RR_EN
            last_i  <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: if (i_req || d_req) begin
                    state   <= pick_d ? REQ_D : REQ_I;
                    mem_req <= 1'b1;
`ifdef ARB_RR_EN
                    last_i  <= !pick_d;
`endif
                end
                REQ_I: if (mem_ready) begin
                    state   <= WAIT_I;
                    mem_req <= 1'b0;
                end
                REQ_D: if (mem_ready) begin
                    state   <= WAIT_D;
                    mem_req <= 1'b0;
                end
                WAIT_I, WAIT_D: if (mem_rvalid) state <= IDLE;
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end
    // Request fields follow the granted requester; they only matter while mem_req is high.
    assign mem_we    = (state == REQ_D) && d_we;
    assign mem_addr  = (state == REQ_D) ? d_addr : i_addr;
    assign mem_wdata = (state == REQ_D) ? d_wdata : '0;
    assign mem_be    = (state == REQ_D) ? d_be : '1;
    // Responses count only in the matching wait state; stray rvalids are dropped.
    assign i_valid = (state == WAIT_I) && mem_rvalid;
    assign d_valid = (state == WAIT_D) && mem_rvalid;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;
    assign StallF  = i_req && !i_valid;
    assign StallM  = d_req && !d_valid;
endmodule
